// File: rtl/alu_uart_pkg.sv
// rtl/alu_uart_pkg.sv - shared ALU opcodes and command-master state encoding
// Contents:
//   cmd_state_t  command-master FSM states
//   OP_*         ALU opcode constants (6-bit function codes)
package alu_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SEND_A   = 3'd1,
        ST_WAIT_A   = 3'd2,
        ST_SEND_B   = 3'd3,
        ST_WAIT_B   = 3'd4,
        ST_SEND_OP  = 3'd5,
        ST_WAIT_OP  = 3'd6,
        ST_WAIT_RES = 3'd7
    } cmd_state_t;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_NOR = 6'b100111;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;

endpackage

// File: rtl/cmd_timer.sv
// rtl/cmd_timer.sv - saturating result-wait timer for the ALU command master
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   clear      holds the count at zero (asserted whenever not waiting)
//   enable     advances the count by one per cycle
//   expired    count has reached TIMEOUT_CYCLES-1
module cmd_timer #(
    parameter int TIMEOUT_CYCLES = 5000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;

    assign expired = (cnt_q == LAST);

    // Saturates at LAST so expired stays high until the owner clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable && !expired) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/alu_cmd_master.sv
// rtl/alu_cmd_master.sv - sends an A/B/opcode frame over UART and waits for the ALU result byte
// Optional feature: define ALU_CMD_TIMEOUT_EN to abandon the result wait after TIMEOUT_CYCLES.
// Ports:
//   i_clock, i_reset              clock, asynchronous active-high reset
//   i_start, i_op_a, i_op_b,
//   i_opcode                      command request and its operands (latched in IDLE)
//   o_tx_ready, o_tx_data,
//   i_tx_done_tick                byte-send handshake with the UART transmitter
//   i_rx_done_tick, i_rx_data     result byte from the UART receiver
//   o_result, o_result_valid      last accepted result and its one-cycle strobe
//   o_busy, o_timeout             frame in progress, result-wait abandoned strobe
module alu_cmd_master
    import alu_uart_pkg::*;
#(
    parameter int NB_DATA        = 8,
    parameter int NB_OP          = 6,
    parameter int TIMEOUT_CYCLES = 5000000
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [NB_DATA-1:0] i_op_a,
    input  logic [NB_DATA-1:0] i_op_b,
    input  logic [NB_OP-1:0]   i_opcode,
    output logic               o_tx_ready,
    output logic [NB_DATA-1:0] o_tx_data,
    input  logic               i_tx_done_tick,
    input  logic               i_rx_done_tick,
    input  logic [NB_DATA-1:0] i_rx_data,
    output logic [NB_DATA-1:0] o_result,
    output logic               o_result_valid,
    output logic               o_busy,
    output logic               o_timeout
);

    cmd_state_t         state_q, state_d;
    logic [NB_DATA-1:0] op_b_q, op_b_d;
    logic [NB_OP-1:0]   opcode_q, opcode_d;
    logic [NB_DATA-1:0] tx_data_q, tx_data_d;
    logic [NB_DATA-1:0] result_q, result_d;
    logic               result_valid_q, result_valid_d;
    logic               timed_out;

`ifdef ALU_CMD_TIMEOUT_EN
    logic timer_expired;

    // Held clear outside WAIT_RES, so every entry starts from zero.
    cmd_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_cmd_timer (
        .clk    (i_clock),
        .rst    (i_reset),
        .clear  (state_q != ST_WAIT_RES),
        .enable (state_q == ST_WAIT_RES),
        .expired(timer_expired)
    );

    // A result byte arriving on the expiry cycle wins over the timeout.
    assign timed_out = (state_q == ST_WAIT_RES) && timer_expired && !i_rx_done_tick;
`else
    assign timed_out = 1'b0;
`endif

    assign o_timeout      = timed_out;
    assign o_busy         = (state_q != ST_IDLE);
    assign o_tx_ready     = (state_q == ST_SEND_A) || (state_q == ST_SEND_B) ||
                            (state_q == ST_SEND_OP);
    assign o_tx_data      = tx_data_q;
    assign o_result       = result_q;
    assign o_result_valid = result_valid_q;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q        <= ST_IDLE;
            op_b_q         <= '0;
            opcode_q       <= '0;
            tx_data_q      <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            op_b_q         <= op_b_d;
            opcode_q       <= opcode_d;
            tx_data_q      <= tx_data_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
        end
    end

    // tx_data is loaded on the transition into each SEND state and then held
    // through the matching WAIT state; operand A goes straight into it.
    always_comb begin
        state_d        = state_q;
        op_b_d         = op_b_q;
        opcode_d       = opcode_q;
        tx_data_d      = tx_data_q;
        result_d       = result_q;
        result_valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    tx_data_d = i_op_a;
                    op_b_d    = i_op_b;
                    opcode_d  = i_opcode;
                    state_d   = ST_SEND_A;
                end
            end
            ST_SEND_A:  state_d = ST_WAIT_A;
            ST_WAIT_A: begin
                if (i_tx_done_tick) begin
                    tx_data_d = op_b_q;
                    state_d   = ST_SEND_B;
                end
            end
            ST_SEND_B:  state_d = ST_WAIT_B;
            ST_WAIT_B: begin
                if (i_tx_done_tick) begin
                    tx_data_d = NB_DATA'(opcode_q);
                    state_d   = ST_SEND_OP;
                end
            end
            ST_SEND_OP: state_d = ST_WAIT_OP;
            ST_WAIT_OP: begin
                if (i_tx_done_tick) begin
                    state_d = ST_WAIT_RES;
                end
            end
            ST_WAIT_RES: begin
                if (i_rx_done_tick) begin
                    result_d       = i_rx_data;
                    result_valid_d = 1'b1;
                    state_d        = ST_IDLE;
                end else if (timed_out) begin
                    state_d = ST_IDLE;
                end
            end
            default:    state_d = ST_IDLE;
        endcase
    end

endmodule
